// File: rtl/fpadd_controller_pkg.sv
// ---------------------------------------------------------------------------
// fpadd_controller_pkg
// Shared types and constants for the single-precision adder sequencer:
//   - operand/sum widths of the floating point datapath
//   - fpadd_state_t : sequencer states
//   - ctrl_t        : registered selects and shift fields driven to datapath
//   - sat_shift()   : |exponent difference| clamped to the pre-shift limit
// ---------------------------------------------------------------------------
package fpadd_controller_pkg;

  localparam int EXP_W        = 8;
  localparam int MANT_W       = 23;
  localparam int SUM_W        = MANT_W + 2;
  localparam int PRESHIFT_MAX = 27;
  localparam int SHIFT_W      = 5;
  localparam int DIFF_W       = EXP_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_RENORM,
    ST_DONE
  } fpadd_state_t;

  // Everything the datapath needs that must persist between stages.
  typedef struct packed {
    logic               sel;
    logic [SHIFT_W-1:0] pre_shift;
    logic               add_sub;
    logic               sum_shift_select;
    logic [SHIFT_W-1:0] norm_shift;
    logic               norm_dir;
    logic               exp_incr_select;
    logic               exp_incr;
    logic [SHIFT_W-1:0] exp_amount;
  } ctrl_t;

  // Shifting past mantissa + guard/round/sticky gains nothing, so the
  // magnitude saturates. The two's complement negate also covers -256,
  // whose magnitude 256 still fits in DIFF_W unsigned bits.
  function automatic logic [SHIFT_W-1:0] sat_shift(input logic [DIFF_W-1:0] diff);
    logic [DIFF_W-1:0] mag;
    mag = diff[DIFF_W-1] ? ((~diff) + DIFF_W'(1)) : diff;
    if (mag > DIFF_W'(PRESHIFT_MAX))
      return SHIFT_W'(PRESHIFT_MAX);
    else
      return mag[SHIFT_W-1:0];
  endfunction

endpackage

// File: rtl/fpadd_controller_if.sv
// ---------------------------------------------------------------------------
// fpadd_controller_if
// Bundle between the adder datapath and its sequencer.
//   datapath -> sequencer : go, exp_diff, sign_a, sign_b, mant_sum,
//                           rounded_mant
//   sequencer -> datapath : mux selects, shift amounts, exponent adjust,
//                           stage enables, busy/done/zero_sum status
// modport master : datapath / requester side
// modport slave  : the sequencer (fpadd_controller)
// ---------------------------------------------------------------------------
interface fpadd_controller_if;
  import fpadd_controller_pkg::*;

  logic                 go;
  logic [DIFF_W-1:0]    exp_diff;
  logic                 sign_a;
  logic                 sign_b;
  logic [SUM_W-1:0]     mant_sum;
  logic [SUM_W-1:0]     rounded_mant;

  logic                 exp_select;
  logic                 mant_select;
  logic [SHIFT_W-1:0]   pre_shift;
  logic                 add_sub;
  logic                 sum_shift_select;
  logic [SHIFT_W-1:0]   norm_shift;
  logic                 norm_dir;
  logic                 exp_incr_select;
  logic                 exp_incr;
  logic [SHIFT_W-1:0]   exp_amount;
  logic                 align_en;
  logic                 sum_en;
  logic                 norm_en;
  logic                 round_en;
  logic                 busy;
  logic                 done;
  logic                 zero_sum;

  modport master (
    output go, exp_diff, sign_a, sign_b, mant_sum, rounded_mant,
    input  exp_select, mant_select, pre_shift, add_sub, sum_shift_select,
           norm_shift, norm_dir, exp_incr_select, exp_incr, exp_amount,
           align_en, sum_en, norm_en, round_en, busy, done, zero_sum
  );

  modport slave (
    input  go, exp_diff, sign_a, sign_b, mant_sum, rounded_mant,
    output exp_select, mant_select, pre_shift, add_sub, sum_shift_select,
           norm_shift, norm_dir, exp_incr_select, exp_incr, exp_amount,
           align_en, sum_en, norm_en, round_en, busy, done, zero_sum
  );

endinterface

// File: rtl/fpadd_controller_lod.sv
// ---------------------------------------------------------------------------
// leading_one_detector
// Combinational priority encoder over the Big ALU sum.
//   value    in  SUM_W   magnitude to scan
//   index    out SHIFT_W bit position of the most significant 1
//   all_zero out 1       value has no bits set (index is 0 then)
// ---------------------------------------------------------------------------
module leading_one_detector
  import fpadd_controller_pkg::*;
(
  input  logic [SUM_W-1:0]   value,
  output logic [SHIFT_W-1:0] index,
  output logic               all_zero
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    index    = '0;
    all_zero = 1'b1;
    for (int i = 0; i < SUM_W; i++) begin
      if (value[i]) begin
        index    = SHIFT_W'(i);
        all_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fpadd_controller.sv
// ---------------------------------------------------------------------------
// fpadd_controller
// Multi-cycle sequencer for the single-precision adder datapath. Accepts a
// go request, latches sign/exponent-difference decisions, then walks the
// datapath through align, add, normalize, round and an optional
// renormalize stage before pulsing done for one cycle.
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset; all outputs go to 0
//   bus   slave modport of fpadd_controller_if (operands in, controls out)
// All outputs are decoded from state and registered fields only.
// ---------------------------------------------------------------------------
module fpadd_controller
  import fpadd_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  fpadd_controller_if.slave  bus
);

  fpadd_state_t state_q, state_d;
  ctrl_t        ctrl_q, ctrl_d;
  logic         zero_q, zero_d;

  logic [SHIFT_W-1:0] lead_index;
  logic               sum_is_zero;

  // Only the round carry-out matters here; the rest of the rounded
  // mantissa goes straight back into the datapath.
  logic unused_rounded;
  assign unused_rounded = ^bus.rounded_mant[SUM_W-2:0];

  leading_one_detector u_lod (
    .value    (bus.mant_sum),
    .index    (lead_index),
    .all_zero (sum_is_zero)
  );

  // State, control fields and the sticky zero flag share one register
  // stage so reset clears every output in the same instant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state logic updates the control fields on the transition into
  // the stage that uses them, so each stage sees stable Moore values.
  // Output decode follows from state_q and the registered fields.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    zero_d  = zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.go) begin
          ctrl_d.sel       = bus.exp_diff[DIFF_W-1];
          ctrl_d.pre_shift = sat_shift(bus.exp_diff);
          ctrl_d.add_sub   = bus.sign_a ^ bus.sign_b;
          zero_d           = 1'b0;
          state_d          = ST_ALIGN;
        end
      end

      ST_ALIGN: state_d = ST_ADD;

      ST_ADD: begin
        if (sum_is_zero) begin
          zero_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          // A carry out needs a one-place right shift; otherwise shift
          // left until the leading one lands on the hidden bit.
          if (bus.mant_sum[SUM_W-1]) begin
            ctrl_d.norm_dir   = 1'b1;
            ctrl_d.norm_shift = SHIFT_W'(1);
            ctrl_d.exp_incr   = 1'b1;
            ctrl_d.exp_amount = SHIFT_W'(1);
          end else begin
            ctrl_d.norm_dir   = 1'b0;
            ctrl_d.norm_shift = SHIFT_W'(MANT_W) - lead_index;
            ctrl_d.exp_incr   = 1'b0;
            ctrl_d.exp_amount = SHIFT_W'(MANT_W) - lead_index;
          end
          ctrl_d.sum_shift_select = 1'b0;
          ctrl_d.exp_incr_select  = 1'b0;
          state_d                 = ST_NORM;
        end
      end

      ST_NORM: state_d = ST_ROUND;

      ST_ROUND: begin
        // Rounding overflow: one extra right shift of the rounded value.
        // The bit shifted out is 0, so no second rounding pass is needed.
        if (bus.rounded_mant[SUM_W-1]) begin
          ctrl_d.sum_shift_select = 1'b1;
          ctrl_d.exp_incr_select  = 1'b1;
          ctrl_d.norm_dir         = 1'b1;
          ctrl_d.norm_shift       = SHIFT_W'(1);
          ctrl_d.exp_incr         = 1'b1;
          ctrl_d.exp_amount       = SHIFT_W'(1);
          state_d                 = ST_RENORM;
        end else begin
          state_d = ST_DONE;
        end
      end

      ST_RENORM: state_d = ST_DONE;

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    bus.exp_select       = ctrl_q.sel;
    bus.mant_select      = ctrl_q.sel;
    bus.pre_shift        = ctrl_q.pre_shift;
    bus.add_sub          = ctrl_q.add_sub;
    bus.sum_shift_select = ctrl_q.sum_shift_select;
    bus.norm_shift       = ctrl_q.norm_shift;
    bus.norm_dir         = ctrl_q.norm_dir;
    bus.exp_incr_select  = ctrl_q.exp_incr_select;
    bus.exp_incr         = ctrl_q.exp_incr;
    bus.exp_amount       = ctrl_q.exp_amount;
    bus.align_en         = (state_q == ST_ALIGN);
    bus.sum_en           = (state_q == ST_ADD);
    bus.norm_en          = (state_q == ST_NORM) || (state_q == ST_RENORM);
    bus.round_en         = (state_q == ST_ROUND);
    bus.busy             = (state_q != ST_IDLE);
    bus.done             = (state_q == ST_DONE);
    bus.zero_sum         = zero_q;
  end

endmodule
